imem_fetch_responder: RTL and testbench

Instruction-memory responder at the memory end of the instruction-fetch interface. The fetch stage issues word fetch requests; this block serves them from an internal instruction array after a programmable number of wait states. Each response is returned over a valid/ready handshake. A program-load port writes the array before or during execution. The block sits between the fetch stage's PC logic and the instruction memory, replacing a zero-latency combinational ROM.

---
 rtl/imem_fetch_responder_if.sv | 33 +++
 rtl/imem_fetch_responder.sv | 127 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
// imem_fetch_responder_if
//   Bundles the fetch-request, response handshake and program-load signals
//   exchanged between the fetch stage and the instruction-memory responder.
//
//   Fetch side  : Fetch_Req, Fetch_Addr -> Fetch_Gnt
//   Response    : Instr, Instr_Valid, Fetch_Err, Fetch_Count -> Instr_Ready
//   Program load: Load_En, Load_Addr, Load_Data
//
//   modport master : fetch stage / loader side
//   modport slave  : memory responder side
interface imem_fetch_responder_if;
    logic        Fetch_Req;
    logic [31:0] Fetch_Addr;
    logic        Fetch_Gnt;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Fetch_Err;
    logic        Load_En;
    logic [31:0] Load_Addr;
    logic [31:0] Load_Data;
    logic [15:0] Fetch_Count;

    modport master (
        output Fetch_Req, Fetch_Addr, Instr_Ready, Load_En, Load_Addr, Load_Data,
        input  Fetch_Gnt, Instr, Instr_Valid, Fetch_Err, Fetch_Count
    );

    modport slave (
        input  Fetch_Req, Fetch_Addr, Instr_Ready, Load_En, Load_Addr, Load_Data,
        output Fetch_Gnt, Instr, Instr_Valid, Fetch_Err, Fetch_Count
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Instruction-memory responder. Accepts one word fetch at a time, waits
//   WAIT_STATES cycles, then presents the word over a valid/ready handshake.
//   A program-load port writes the internal array at any time.
//
//   Ports:
//     Clk    - clock, rising edge
//     Reset  - synchronous active-low reset (array contents are kept)
//     bus    - imem_fetch_responder_if.slave (fetch, response, load signals)
//
//   State table:
//     S_IDLE | waiting for Fetch_Req; grants combinationally
//     S_WAIT | counting wait states; array read on the last one
//     S_RESP | Instr_Valid high, outputs held until Instr_Ready
module imem_fetch_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input logic                   Clk,
    input logic                   Reset,
    imem_fetch_responder_if.slave bus
);

    localparam int AW      = $clog2(DEPTH);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q;
    logic [31:0] addr_q;
    logic [3:0]  cnt_q;
    logic [31:0] instr_q;
    logic        err_q;
    logic        valid_q;
    logic [15:0] count_q;

    logic [31:0]   rd_addr;
    logic [AW-1:0] rd_idx;
    logic [31:0]   instr_d;
    logic          err_d;
    logic [AW-1:0] ld_idx;
    logic          ld_bad;

    // With zero wait states the read happens at the grant edge, so the
    // address comes straight from the request rather than the latch.
    always_comb begin
        rd_addr = (state_q == S_IDLE) ? bus.Fetch_Addr : addr_q;
        rd_idx  = rd_addr[AW+1:2];
        err_d   = (rd_addr[1:0] != 2'b00) || ({2'b00, rd_addr[31:2]} >= 32'(DEPTH));
        instr_d = err_d ? 32'h0000_0000 : mem[rd_idx];
    end

    always_comb begin
        ld_idx = bus.Load_Addr[AW+1:2];
        ld_bad = (bus.Load_Addr[1:0] != 2'b00) || ({2'b00, bus.Load_Addr[31:2]} >= 32'(DEPTH));
    end

    assign bus.Fetch_Gnt   = Reset && (state_q == S_IDLE) && bus.Fetch_Req;
    assign bus.Instr       = instr_q;
    assign bus.Instr_Valid = valid_q;
    assign bus.Fetch_Err   = err_q;
    assign bus.Fetch_Count = count_q;

    // Loads ignore reset and FSM state. The read above samples the array
    // combinationally before this edge's write lands, giving read-before-write.
    always_ff @(posedge Clk) begin
        if (bus.Load_En && !ld_bad) begin
            mem[ld_idx] <= bus.Load_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            cnt_q   <= 4'd0;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            count_q <= 16'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Fetch_Req) begin
                        addr_q <= bus.Fetch_Addr;
                        cnt_q  <= 4'(WAIT_STATES);
                        if (NO_WAIT) begin
                            instr_q <= instr_d;
                            err_q   <= err_d;
                            valid_q <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        instr_q <= instr_d;
                        err_q   <= err_d;
                        valid_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.Instr_Ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 16'd1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

    localparam int DEPTH  = 1024;
    localparam int WS     = 2;
    localparam int DEPTH0 = 16;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    imem_fetch_responder_if bus ();
    imem_fetch_responder_if bus0 ();

    imem_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    imem_fetch_responder #(.DEPTH(DEPTH0), .WAIT_STATES(0)) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0)
    );

    logic [31:0] mem_m  [DEPTH];
    logic [31:0] mem0_m [DEPTH0];
    logic [32:0] sb  [$];
    logic [32:0] sb0 [$];

    int          nchk = 0;
    int          npass = 0;
    logic [15:0] exp_cnt = 16'h0;

    bit          g;
    bit          ok;
    int          lat;
    logic [31:0] ins;
    logic        err;
    logic [32:0] expv;

    function automatic logic [32:0] exp_word(input logic [31:0] a);
        logic [9:0] idx;
        idx = a[11:2];
        if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) return {1'b1, 32'h0};
        return {1'b0, mem_m[idx]};
    endfunction

    function automatic logic [32:0] exp_word0(input logic [31:0] a);
        logic [3:0] idx;
        idx = a[5:2];
        if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH0)) return {1'b1, 32'h0};
        return {1'b0, mem0_m[idx]};
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        logic [9:0] idx;
        idx = a[11:2];
        bus.Load_En   = 1'b1;
        bus.Load_Addr = a;
        bus.Load_Data = d;
        @(negedge Clk);
        bus.Load_En = 1'b0;
        if (!(a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH))) mem_m[idx] = d;
    endtask

    task automatic issue(input logic [31:0] a, output bit granted);
        granted = 1'b0;
        bus.Fetch_Req  = 1'b1;
        bus.Fetch_Addr = a;
        for (int i = 0; i < 40 && !granted; i++) begin
            #1;
            if (bus.Fetch_Gnt === 1'b1) granted = 1'b1;
            else @(negedge Clk);
        end
        if (granted) sb.push_back(exp_word(a));
        @(negedge Clk);
        bus.Fetch_Req = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] i_o, output logic e_o, output int l_o, output bit ok_o);
        l_o = 0;
        while (bus.Instr_Valid !== 1'b1 && l_o < 40) begin
            @(negedge Clk);
            l_o++;
        end
        ok_o = (bus.Instr_Valid === 1'b1);
        i_o  = bus.Instr;
        e_o  = bus.Fetch_Err;
    endtask

    task automatic consume;
        bus.Instr_Ready = 1'b1;
        @(negedge Clk);
        bus.Instr_Ready = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        bus.Fetch_Req = 1'b1;
        bus.Fetch_Addr = 32'h0;
        repeat (2) @(negedge Clk);
        #1;
        nchk++;
        if (bus.Fetch_Gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", bus.Fetch_Gnt);
        else npass++;
        nchk++;
        if ({bus.Instr_Valid, bus.Fetch_Err, bus.Instr, bus.Fetch_Count} !== 50'h0)
            $display("FAIL reset_outputs: valid=%b err=%b instr=%h count=%h want all zero",
                     bus.Instr_Valid, bus.Fetch_Err, bus.Instr, bus.Fetch_Count);
        else npass++;
        nchk++;
        if ({bus0.Instr_Valid, bus0.Fetch_Count} !== 17'h0)
            $display("FAIL reset_outputs0: valid=%b count=%h want 0", bus0.Instr_Valid, bus0.Fetch_Count);
        else npass++;
        bus.Fetch_Req = 1'b0;
        Reset = 1'b1;
        exp_cnt = 16'h0;
        @(negedge Clk);
    endtask

    task automatic test_basic;
        logic [31:0] addrs [3];
        addrs = '{32'h8, 32'h0, 32'hC};
        for (int k = 0; k < 4; k++) do_load(32'(k * 4), 32'h1111_1111 * 32'(k + 1));
        for (int k = 0; k < 3; k++) begin
            issue(addrs[k], g);
            nchk++;
            if (!g) $display("FAIL basic_gnt: addr=%h no grant within bound", addrs[k]);
            else begin
                npass++;
                wait_resp(ins, err, lat, ok);
                nchk++;
                if (!ok || lat != WS) $display("FAIL basic_latency: valid=%b cycles=%0d want %0d", ok, lat, WS);
                else npass++;
                expv = sb.pop_front();
                nchk++;
                if ({err, ins} !== expv) $display("FAIL basic_data: got err=%b instr=%h want err=%b instr=%h", err, ins, expv[32], expv[31:0]);
                else npass++;
                consume();
                exp_cnt++;
                nchk++;
                if (bus.Fetch_Count !== exp_cnt) $display("FAIL basic_count: got %h want %h", bus.Fetch_Count, exp_cnt);
                else npass++;
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [4];
        addrs = '{32'h6, 32'(4 * DEPTH), 32'h4, 32'h0};
        do_load(32'h6, 32'hDEAD_BEEF);
        do_load(32'(4 * DEPTH), 32'hCAFE_F00D);
        for (int k = 0; k < 4; k++) begin
            issue(addrs[k], g);
            nchk++;
            if (!g) $display("FAIL err_gnt: addr=%h no grant within bound", addrs[k]);
            else begin
                npass++;
                wait_resp(ins, err, lat, ok);
                nchk++;
                if (!ok || lat != WS) $display("FAIL err_latency: addr=%h valid=%b cycles=%0d want %0d", addrs[k], ok, lat, WS);
                else npass++;
                expv = sb.pop_front();
                nchk++;
                if ({err, ins} !== expv) $display("FAIL err_data: addr=%h got err=%b instr=%h want err=%b instr=%h", addrs[k], err, ins, expv[32], expv[31:0]);
                else npass++;
                consume();
                exp_cnt++;
            end
        end
    endtask

    task automatic test_backpressure;
        issue(32'hC, g);
        wait_resp(ins, err, lat, ok);
        nchk++;
        if (!g || !ok) $display("FAIL bp_resp: gnt=%b valid=%b want 1/1", g, ok);
        else npass++;
        expv = (sb.size() > 0) ? sb.pop_front() : 33'h0;
        bus.Fetch_Req  = 1'b1;
        bus.Fetch_Addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            bus.Load_En   = (i == 0);
            bus.Load_Addr = 32'hC;
            bus.Load_Data = 32'h5555_5555;
            #1;
            nchk++;
            if (bus.Instr_Valid !== 1'b1 || {bus.Fetch_Err, bus.Instr} !== expv)
                $display("FAIL bp_hold: cycle=%0d valid=%b err=%b instr=%h want 1/%b/%h", i, bus.Instr_Valid, bus.Fetch_Err, bus.Instr, expv[32], expv[31:0]);
            else npass++;
            nchk++;
            if (bus.Fetch_Gnt !== 1'b0) $display("FAIL bp_gnt: cycle=%0d got %b want 0", i, bus.Fetch_Gnt);
            else npass++;
            @(negedge Clk);
        end
        bus.Load_En   = 1'b0;
        bus.Fetch_Req = 1'b0;
        mem_m[3] = 32'h5555_5555;
        consume();
        exp_cnt++;
        nchk++;
        if (bus.Fetch_Count !== exp_cnt) $display("FAIL bp_count: got %h want %h", bus.Fetch_Count, exp_cnt);
        else npass++;
        issue(32'hC, g);
        wait_resp(ins, err, lat, ok);
        expv = (sb.size() > 0) ? sb.pop_front() : 33'h0;
        nchk++;
        if (!g || !ok || {err, ins} !== expv || expv !== {1'b0, 32'h5555_5555})
            $display("FAIL bp_newval: gnt=%b valid=%b got err=%b instr=%h want err=0 instr=55555555", g, ok, err, ins);
        else npass++;
        consume();
        exp_cnt++;
    endtask

    task automatic test_same_cycle;
        issue(32'h8, g);
        repeat (WS - 1) @(negedge Clk);
        do_load(32'h8, 32'h7777_7777);
        wait_resp(ins, err, lat, ok);
        expv = (sb.size() > 0) ? sb.pop_front() : 33'h0;
        nchk++;
        if (!g || !ok || lat != 0 || {err, ins} !== expv)
            $display("FAIL rbw_old: gnt=%b valid=%b lat=%0d got err=%b instr=%h want err=%b instr=%h", g, ok, lat, err, ins, expv[32], expv[31:0]);
        else npass++;
        consume();
        exp_cnt++;
        issue(32'h8, g);
        wait_resp(ins, err, lat, ok);
        expv = (sb.size() > 0) ? sb.pop_front() : 33'h0;
        nchk++;
        if (!g || !ok || {err, ins} !== expv)
            $display("FAIL rbw_new: gnt=%b valid=%b got err=%b instr=%h want err=%b instr=%h", g, ok, err, ins, expv[32], expv[31:0]);
        else npass++;
        consume();
        exp_cnt++;
    endtask

    task automatic test_reset_mid;
        bit seen_valid;
        issue(32'h4, g);
        Reset         = 1'b0;
        bus.Load_En   = 1'b1;
        bus.Load_Addr = 32'h14;
        bus.Load_Data = 32'h9999_9999;
        @(negedge Clk);
        Reset       = 1'b1;
        bus.Load_En = 1'b0;
        mem_m[5] = 32'h9999_9999;
        if (g && sb.size() > 0) void'(sb.pop_back());
        exp_cnt = 16'h0;
        nchk++;
        if ({bus.Instr_Valid, bus.Fetch_Err, bus.Instr, bus.Fetch_Count} !== 50'h0)
            $display("FAIL rstmid_outputs: valid=%b err=%b instr=%h count=%h want all zero",
                     bus.Instr_Valid, bus.Fetch_Err, bus.Instr, bus.Fetch_Count);
        else npass++;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.Instr_Valid !== 1'b0) seen_valid = 1'b1;
            @(negedge Clk);
        end
        nchk++;
        if (seen_valid) $display("FAIL rstmid_novalid: got valid=1 want 0 after discarded fetch");
        else npass++;
        for (int k = 0; k < 2; k++) begin
            issue((k == 0) ? 32'h14 : 32'h4, g);
            wait_resp(ins, err, lat, ok);
            expv = (sb.size() > 0) ? sb.pop_front() : 33'h0;
            nchk++;
            if (!g || !ok || lat != WS || {err, ins} !== expv)
                $display("FAIL rstmid_fetch%0d: gnt=%b valid=%b lat=%0d got err=%b instr=%h want err=%b instr=%h", k, g, ok, lat, err, ins, expv[32], expv[31:0]);
            else npass++;
            consume();
            exp_cnt++;
            nchk++;
            if (bus.Fetch_Count !== exp_cnt) $display("FAIL rstmid_count%0d: got %h want %h", k, bus.Fetch_Count, exp_cnt);
            else npass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] cnt0;
        logic [31:0] a0;
        int          last;
        int          nresp;
        bit          gg;
        for (int k = 0; k < 8; k++) begin
            bus0.Load_En   = 1'b1;
            bus0.Load_Addr = 32'(k * 4);
            bus0.Load_Data = 32'hA000_0000 + 32'h0101_0101 * 32'(k);
            @(negedge Clk);
            mem0_m[k] = 32'hA000_0000 + 32'h0101_0101 * 32'(k);
        end
        bus0.Load_En = 1'b0;
        force dut0.count_q = 16'hFFFD;
        @(negedge Clk);
        release dut0.count_q;
        cnt0  = 16'hFFFD;
        a0    = 32'h0;
        last  = -1;
        nresp = 0;
        bus0.Fetch_Addr  = a0;
        bus0.Fetch_Req   = 1'b1;
        bus0.Instr_Ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nresp < 8; cyc++) begin
            #1;
            gg = bus0.Fetch_Gnt;
            if (bus0.Instr_Valid === 1'b1) begin
                expv = (sb0.size() > 0) ? sb0.pop_front() : 33'h0;
                nchk++;
                if ({bus0.Fetch_Err, bus0.Instr} !== expv || bus0.Fetch_Count !== cnt0)
                    $display("FAIL b2b_resp%0d: got err=%b instr=%h count=%h want err=%b instr=%h count=%h", nresp,
                             bus0.Fetch_Err, bus0.Instr, bus0.Fetch_Count, expv[32], expv[31:0], cnt0);
                else npass++;
                cnt0++;
                nresp++;
            end
            if (gg) begin
                sb0.push_back(exp_word0(a0));
                if (last >= 0) begin
                    nchk++;
                    if (cyc - last != 2) $display("FAIL b2b_gap: got %0d cycles want 2", cyc - last);
                    else npass++;
                end
                last = cyc;
            end
            @(posedge Clk);
            #1;
            if (gg) begin
                a0 = a0 + 32'h4;
                bus0.Fetch_Addr = a0;
                if (a0 == 32'h20) bus0.Fetch_Req = 1'b0;
            end
            @(negedge Clk);
        end
        bus0.Fetch_Req   = 1'b0;
        bus0.Instr_Ready = 1'b0;
        nchk++;
        if (nresp != 8 || bus0.Fetch_Count !== 16'h0005)
            $display("FAIL b2b_wrap: responses=%0d count=%h want 8 and 0005", nresp, bus0.Fetch_Count);
        else npass++;
    endtask

    initial begin
        Reset = 1'b0;
        bus.Fetch_Req = 1'b0;   bus.Fetch_Addr = 32'h0;  bus.Instr_Ready = 1'b0;
        bus.Load_En = 1'b0;     bus.Load_Addr = 32'h0;   bus.Load_Data = 32'h0;
        bus0.Fetch_Req = 1'b0;  bus0.Fetch_Addr = 32'h0; bus0.Instr_Ready = 1'b0;
        bus0.Load_En = 1'b0;    bus0.Load_Addr = 32'h0;  bus0.Load_Data = 32'h0;
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        nchk++;
        if (sb.size() != 0 || sb0.size() != 0) $display("FAIL sb_empty: leftover=%0d/%0d want 0/0", sb.size(), sb0.size());
        else npass++;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", npass, nchk);
        $fatal(1, "watchdog");
    end

endmodule
